riscv_soft_dmem_resp: RTL and testbench
=======================================

// Module: riscv_soft_dmem_resp
// PURPOSE
// - Responder end of the core's dcache request/response interface.
// - Accepts LOAD/STORE/FENCE requests from the pipeline control. Executes them on a word-organised
//   data RAM, with programmable wait states.
// - Returns sign- or zero-extended load data.
// - dcache_resp_valid is the WB-stage go signal: it is high whenever no accepted request is
//   outstanding.
// PARAMETERS
// - XPR_LEN      32  data/address width
// - DEPTH_LOG2   10  log2 of RAM depth in 32-bit words (4 KiB default)
// - WAIT_CYCLES  0   extra busy cycles per request, 0..255
// PORTS
// - clk                     in   1        rising-edge clock
// - reset                   in   1        synchronous, active-high
// - dcache_req_valid        in   1        request present
// - dcache_req_ready        out  1        responder can accept
// - dcache_req_op           in   2        0=MEM_LOAD 1=MEM_STORE 2=MEM_FENCE 3=reserved(as FENCE)
// - dcache_op_type          in   3        funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; others = W
// - dcache_req_addr         in   XPR_LEN  byte address
// - dcache_req_data         in   XPR_LEN  store data, low bits used for B/H
// - dcache_resp_valid       out  1        no request outstanding; resp_data valid after a load
// - dcache_resp_data        out  XPR_LEN  extended load result
// - dcache_resp_misaligned  out  1        last completed request was misaligned (feature only)
// BEHAVIOUR
// - Accept = req_valid && req_ready on a rising edge. req_valid while !ready is ignored; the
//   requester holds it.
// - FSM IDLE/BUSY:
//   - IDLE: ready=1, resp_valid=1.
//   - Accept with WAIT_CYCLES=0: stay IDLE.
//   - Accept with WAIT_CYCLES>0: capture op/type/addr/data, go BUSY with cnt=WAIT_CYCLES.
//   - BUSY: ready=0, resp_valid=0, cnt decrements each cycle; at cnt==1 return to IDLE.
// - Completion edge:
//   - WAIT_CYCLES=0: the accept edge.
//   - Otherwise: the edge leaving BUSY.
//   - The operation takes effect there. Result visible the next cycle, together with resp_valid=1.
// - Latency: resp data one cycle after accept, plus WAIT_CYCLES. Back-to-back accepts every
//   cycle when WAIT_CYCLES=0.
// - Word index = addr[DEPTH_LOG2+1:2]; higher address bits ignored (aliases wrap).
// - LOAD: the RAM word is read at the completion edge, so it sees every earlier completed store.
//   - Lane select: B/BU use addr[1:0]; H/HU use addr[1].
//   - B/H sign-extend; BU/HU zero-extend; W passes through.
//   - dcache_resp_data holds its value until the next load completes.
// - STORE: at the completion edge, writes B/H/W with byte enables from addr lanes.
//   - Unselected bytes are unchanged.
//   - resp_data is unchanged.
// - FENCE/reserved: no RAM effect; completes with the same timing.
// - Reset:
//   - state=IDLE, cnt=0, resp_data=0, resp_misaligned=0; ready=1 and resp_valid=1 in the first
//     cycle after reset.
//   - RAM contents are not reset.
//   - Reset while BUSY discards the pending request: no write, resp_data unchanged (=0).
//   - Reset asserted coincident with req_valid: nothing is accepted.
// CONFIGURATION
// - DMEM_MISALIGN_TRAP_EN defined: misaligned = (H/HU && addr[0]) || (W && addr[1:0]!=0).
//   - Misaligned store: write suppressed.
//   - Misaligned load: resp_data=0.
//   - dcache_resp_misaligned set at the completion edge of every request (1 if misaligned,
//     else 0) and held until the next completion.
// - DMEM_MISALIGN_TRAP_EN undefined: offending low address bits are ignored (H uses addr[1],
//   W ignores addr[1:0]); dcache_resp_misaligned tied 0.
// TESTING
// - Reset, WAIT=0 -> ready=1, resp_valid=1, resp_data=0.
// - SW 0xDEADBEEF @0x10, then LW @0x10 next cycle -> resp_data=0xDEADBEEF one cycle after the load.
// - LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
// - SB 0x5A @0x11, then LW @0x10 -> 0xDEAD5AEF.
// - WAIT_CYCLES=3, LW accepted at cycle N:
//   - ready=0 and resp_valid=0 in N+1..N+3.
//   - Data appears with resp_valid=1 at N+4.
//   - req_valid held high in N+1..N+3 is not accepted.
// - Misaligned SW @0x12:
//   - With DMEM_MISALIGN_TRAP_EN: RAM unchanged, misaligned=1.
//   - Without: word @0x10 written.
//   - Reset during BUSY of a store: word unchanged.

Source files
------------

// File: rtl/riscv_soft_dmem_resp.sv
// Data-memory responder for the dcache req/resp port with optional wait states.
// Optional misaligned-access trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module riscv_soft_dmem_resp #(
  parameter int XPR_LEN     = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dcache_req_valid,
  output logic               dcache_req_ready,
  input  logic [1:0]         dcache_req_op,
  input  logic [2:0]         dcache_op_type,
  input  logic [XPR_LEN-1:0] dcache_req_addr,
  input  logic [XPR_LEN-1:0] dcache_req_data,
  output logic               dcache_resp_valid,
  output logic [XPR_LEN-1:0] dcache_resp_data,
  output logic               dcache_resp_misaligned
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int NB    = XPR_LEN / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [7:0]         cnt, cnt_nxt;
  logic               accept, done, do_op;
  logic [1:0]         op_q;
  logic [2:0]         ty_q;
  logic [XPR_LEN-1:0] addr_q, data_q;
  logic [1:0]         c_op;
  logic [2:0]         c_ty;
  logic [XPR_LEN-1:0] c_addr, c_data;
  logic               is_b, is_h, is_w, mis;
  logic [DEPTH_LOG2-1:0] idx;
  logic [XPR_LEN-1:0] mem [DEPTH];
  logic [XPR_LEN-1:0] rd_word, ld_val, wdat;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [NB-1:0]      be;
  logic               wr_en, ld_en;
  logic               unused_addr;

  assign dcache_req_ready  = (state == IDLE);
  assign dcache_resp_valid = (state == IDLE);
  assign accept = dcache_req_valid && dcache_req_ready && !reset;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            done = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = 8'(WAIT_CYCLES);
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt == 8'd1) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= dcache_req_op;
      ty_q   <= dcache_op_type;
      addr_q <= dcache_req_addr;
      data_q <= dcache_req_data;
    end
  end

  // Zero-wait requests execute straight from the port; otherwise from the capture.
  assign c_op   = (WAIT_CYCLES == 0) ? dcache_req_op   : op_q;
  assign c_ty   = (WAIT_CYCLES == 0) ? dcache_op_type  : ty_q;
  assign c_addr = (WAIT_CYCLES == 0) ? dcache_req_addr : addr_q;
  assign c_data = (WAIT_CYCLES == 0) ? dcache_req_data : data_q;

  assign do_op = done && !reset;
  assign is_b  = (c_ty[1:0] == 2'b00);
  assign is_h  = (c_ty[1:0] == 2'b01);
  assign is_w  = !is_b && !is_h;
  assign idx   = c_addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^{c_addr[XPR_LEN-1:DEPTH_LOG2+2]};

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = (is_h && c_addr[0]) || (is_w && (c_addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign rd_word = mem[idx];
  assign rd_byte = rd_word[8*c_addr[1:0] +: 8];
  assign rd_half = c_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_val = rd_word;
    wdat   = c_data;
    be     = '1;
    unique case (1'b1)
      is_b: begin
        ld_val = c_ty[2] ? {{(XPR_LEN-8){1'b0}}, rd_byte}
                         : {{(XPR_LEN-8){rd_byte[7]}}, rd_byte};
        wdat   = {NB{c_data[7:0]}};
        be     = NB'(1) << c_addr[1:0];
      end
      is_h: begin
        ld_val = c_ty[2] ? {{(XPR_LEN-16){1'b0}}, rd_half}
                         : {{(XPR_LEN-16){rd_half[15]}}, rd_half};
        wdat   = {(NB/2){c_data[15:0]}};
        be     = c_addr[1] ? NB'(4'b1100) : NB'(4'b0011);
      end
      default: begin
        ld_val = rd_word;
        wdat   = c_data;
        be     = '1;
      end
    endcase
  end

  assign wr_en = do_op && (c_op == 2'd1) && !mis;
  assign ld_en = do_op && (c_op == 2'd0);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dcache_resp_data <= '0;
    end else if (ld_en) begin
      dcache_resp_data <= mis ? '0 : ld_val;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else if (do_op) begin
      mis_q <= mis;
    end
  end
  assign dcache_resp_misaligned = mis_q;
`else
  assign dcache_resp_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_soft_dmem_resp.sv
// Directed bench for riscv_soft_dmem_resp: zero-wait and 3-wait instances.
// Expectations follow DMEM_MISALIGN_TRAP_EN when it is defined.
module tb_riscv_soft_dmem_resp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        v0, r0, rv0, m0;
  logic [1:0]  op0;
  logic [2:0]  ty0;
  logic [31:0] a0, d0, rd0;

  logic        v3, r3, rv3, m3;
  logic [1:0]  op3;
  logic [2:0]  ty3;
  logic [31:0] a3, d3, rd3;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] LD = 2'd0, ST = 2'd1, FN = 2'd2, RSV = 2'd3;
  localparam logic [2:0] TB = 3'b000, TH = 3'b001, TW = 3'b010;
  localparam logic [2:0] TBU = 3'b100, THU = 3'b101;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  riscv_soft_dmem_resp #(.XPR_LEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset),
    .dcache_req_valid(v0), .dcache_req_ready(r0),
    .dcache_req_op(op0), .dcache_op_type(ty0),
    .dcache_req_addr(a0), .dcache_req_data(d0),
    .dcache_resp_valid(rv0), .dcache_resp_data(rd0),
    .dcache_resp_misaligned(m0)
  );

  riscv_soft_dmem_resp #(.XPR_LEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(reset),
    .dcache_req_valid(v3), .dcache_req_ready(r3),
    .dcache_req_op(op3), .dcache_op_type(ty3),
    .dcache_req_addr(a3), .dcache_req_data(d3),
    .dcache_resp_valid(rv3), .dcache_resp_data(rd3),
    .dcache_resp_misaligned(m3)
  );

  task automatic req0(input logic [1:0] op, input logic [2:0] ty,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    v0 = 1'b1; op0 = op; ty0 = ty; a0 = a; d0 = d;
    @(posedge clk);
    #1;
    v0 = 1'b0;
  endtask

  task automatic req3(input logic [1:0] op, input logic [2:0] ty,
                      input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    v3 = 1'b1; op3 = op; ty3 = ty; a3 = a; d3 = d;
    @(posedge clk);
    #1;
    v3 = 1'b0;
    while (!rv3 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (rv3 !== 1'b1) begin
      $display("FAIL req3_timeout resp_valid=%b required=1", rv3);
      bad++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    v0 = 1'b0; op0 = LD; ty0 = TW; a0 = '0; d0 = '0;
    v3 = 1'b0; op3 = LD; ty3 = TW; a3 = '0; d3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total += 7;
    if (r0 !== 1'b1) begin $display("FAIL rst_ready0 got=%b exp=1", r0); bad++; end
    if (rv0 !== 1'b1) begin $display("FAIL rst_rvalid0 got=%b exp=1", rv0); bad++; end
    if (rd0 !== 32'h0) begin $display("FAIL rst_rdata0 got=%h exp=0", rd0); bad++; end
    if (m0 !== 1'b0) begin $display("FAIL rst_mis0 got=%b exp=0", m0); bad++; end
    if (r3 !== 1'b1) begin $display("FAIL rst_ready3 got=%b exp=1", r3); bad++; end
    if (rv3 !== 1'b1) begin $display("FAIL rst_rvalid3 got=%b exp=1", rv3); bad++; end
    if (rd3 !== 32'h0) begin $display("FAIL rst_rdata3 got=%h exp=0", rd3); bad++; end
  endtask

  task automatic test_store_load;
    req0(ST, TW, 32'h10, 32'hDEADBEEF);
    req0(LD, TW, 32'h10, 32'h0);
    total += 3;
    if (rd0 !== 32'hDEADBEEF) begin $display("FAIL lw got=%h exp=deadbeef", rd0); bad++; end
    if (rv0 !== 1'b1) begin $display("FAIL lw_rvalid got=%b exp=1", rv0); bad++; end
    if (r0 !== 1'b1) begin $display("FAIL lw_ready got=%b exp=1", r0); bad++; end
  endtask

  task automatic test_extend;
    logic [2:0]  ty [4];
    logic [31:0] ad [4];
    logic [31:0] ex [4];
    ty = '{TB, TBU, TH, THU};
    ad = '{32'h13, 32'h13, 32'h12, 32'h10};
    ex = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    for (int i = 0; i < 4; i++) begin
      req0(LD, ty[i], ad[i], 32'h0);
      total++;
      if (rd0 !== ex[i]) begin
        $display("FAIL ext%0d got=%h exp=%h", i, rd0, ex[i]);
        bad++;
      end
    end
  endtask

  task automatic test_byte_store;
    req0(ST, TB, 32'h11, 32'hFFFFFF5A);
    total++;
    if (rd0 !== 32'h0000BEEF) begin $display("FAIL sb_keep got=%h exp=0000beef", rd0); bad++; end
    req0(LD, TW, 32'h10, 32'h0);
    total++;
    if (rd0 !== 32'hDEAD5AEF) begin $display("FAIL sb_lw got=%h exp=dead5aef", rd0); bad++; end
  endtask

  task automatic test_half_alias_fence;
    req0(ST, TW, 32'h14, 32'h0);
    req0(ST, TH, 32'h16, 32'hCAFEABCD);
    req0(LD, TW, 32'h14, 32'h0);
    total++;
    if (rd0 !== 32'hABCD0000) begin $display("FAIL sh_lw got=%h exp=abcd0000", rd0); bad++; end
    req0(ST, TW, 32'h1010, 32'h12345678);
    req0(LD, TW, 32'h10, 32'h0);
    total++;
    if (rd0 !== 32'h12345678) begin $display("FAIL alias got=%h exp=12345678", rd0); bad++; end
    req0(FN, TW, 32'h10, 32'h0);
    req0(RSV, TW, 32'h10, 32'h0);
    total++;
    if (rd0 !== 32'h12345678) begin $display("FAIL fence_keep got=%h exp=12345678", rd0); bad++; end
    req0(LD, TB, 32'h14, 32'h0);
    req0(LD, TW, 32'h10, 32'h0);
    total++;
    if (rd0 !== 32'h12345678) begin $display("FAIL fence_ram got=%h exp=12345678", rd0); bad++; end
  endtask

  task automatic test_misaligned;
    logic [31:0] exp_w, exp_h;
    exp_w = TRAP ? 32'h12345678 : 32'h11223344;
    exp_h = TRAP ? 32'h00000000 : 32'h00003344;
    req0(ST, TW, 32'h12, 32'h11223344);
    total++;
    if (m0 !== TRAP) begin $display("FAIL mis_sw_flag got=%b exp=%b", m0, TRAP); bad++; end
    req0(LD, TW, 32'h10, 32'h0);
    total += 2;
    if (rd0 !== exp_w) begin $display("FAIL mis_sw_ram got=%h exp=%h", rd0, exp_w); bad++; end
    if (m0 !== 1'b0) begin $display("FAIL mis_clear got=%b exp=0", m0); bad++; end
    req0(LD, TH, 32'h11, 32'h0);
    total += 2;
    if (rd0 !== exp_h) begin $display("FAIL mis_lh got=%h exp=%h", rd0, exp_h); bad++; end
    if (m0 !== TRAP) begin $display("FAIL mis_lh_flag got=%b exp=%b", m0, TRAP); bad++; end
  endtask

  task automatic test_wait3;
    req3(ST, TW, 32'h20, 32'h13579BDF);
    @(negedge clk);
    v3 = 1'b1; op3 = LD; ty3 = TW; a3 = 32'h20; d3 = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      total += 3;
      if (r3 !== 1'b0) begin $display("FAIL busy_ready%0d got=%b exp=0", i, r3); bad++; end
      if (rv3 !== 1'b0) begin $display("FAIL busy_rvalid%0d got=%b exp=0", i, rv3); bad++; end
      if (rd3 !== 32'h0) begin $display("FAIL busy_rdata%0d got=%h exp=0", i, rd3); bad++; end
      @(posedge clk);
      #1;
    end
    total += 3;
    if (r3 !== 1'b1) begin $display("FAIL w3_ready got=%b exp=1", r3); bad++; end
    if (rv3 !== 1'b1) begin $display("FAIL w3_rvalid got=%b exp=1", rv3); bad++; end
    if (rd3 !== 32'h13579BDF) begin $display("FAIL w3_data got=%h exp=13579bdf", rd3); bad++; end
    v3 = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (rv3 !== 1'b1) begin $display("FAIL w3_idle got=%b exp=1", rv3); bad++; end
  endtask

  task automatic test_reset_busy;
    @(negedge clk);
    v3 = 1'b1; op3 = ST; ty3 = TW; a3 = 32'h20; d3 = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    v3 = 1'b0;
    total++;
    if (rv3 !== 1'b0) begin $display("FAIL rb_busy got=%b exp=0", rv3); bad++; end
    @(negedge clk);
    reset = 1'b1;
    v0 = 1'b1; op0 = ST; ty0 = TW; a0 = 32'h14; d0 = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    v0 = 1'b0;
    #1;
    total += 3;
    if (rv3 !== 1'b1) begin $display("FAIL rb_rvalid got=%b exp=1", rv3); bad++; end
    if (rd3 !== 32'h0) begin $display("FAIL rb_rdata3 got=%h exp=0", rd3); bad++; end
    if (rd0 !== 32'h0) begin $display("FAIL rb_rdata0 got=%h exp=0", rd0); bad++; end
    req3(LD, TW, 32'h20, 32'h0);
    total++;
    if (rd3 !== 32'h13579BDF) begin $display("FAIL rb_ram got=%h exp=13579bdf", rd3); bad++; end
    req0(LD, TW, 32'h14, 32'h0);
    total++;
    if (rd0 !== 32'hABCD0000) begin $display("FAIL rb_coinc got=%h exp=abcd0000", rd0); bad++; end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_extend();
    test_byte_store();
    test_half_alias_fence();
    test_misaligned();
    test_wait3();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
